// File: rtl/pattern_source_gen_pkg.sv
// Shared mode codes, PRBS polynomial constants and the mode-handshake state type
// for the multi-mode FMC test-pattern source.
package pattern_gen_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_COUNT     = 3'd0;
    localparam logic [MODE_W-1:0] MODE_PRBS7     = 3'd1;
    localparam logic [MODE_W-1:0] MODE_PRBS15    = 3'd2;
    localparam logic [MODE_W-1:0] MODE_PRBS31    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_CONST     = 3'd4;
    localparam logic [MODE_W-1:0] MODE_CONST_BAR = 3'd5;
    localparam logic [MODE_W-1:0] MODE_WALK      = 3'd6;
    localparam logic [MODE_W-1:0] MODE_USER      = 3'd7;

    // Polynomial x^ORDER + x^TAP + 1
    localparam int unsigned PRBS7_ORDER  = 7;
    localparam int unsigned PRBS7_TAP    = 6;
    localparam int unsigned PRBS15_ORDER = 15;
    localparam int unsigned PRBS15_TAP   = 14;
    localparam int unsigned PRBS31_ORDER = 31;
    localparam int unsigned PRBS31_TAP   = 28;

    localparam int unsigned PRBS_SEED_W  = PRBS31_ORDER;

    // COMMIT covers the gap between the boundary word and the first new-mode word
    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_PENDING = 2'd1,
        HS_COMMIT  = 2'd2
    } hs_state_e;

endpackage

// File: rtl/pattern_source_gen_if.sv
// Mode-request handshake plus the emitted pattern stream of the pattern source.
// master = controlling side, slave = the generator.
interface pattern_source_gen_if
    import pattern_gen_pkg::*;
#(
    parameter int unsigned W = 16
);

    logic [MODE_W-1:0] mode_req;
    logic              mode_valid;
    logic              mode_ready;
    logic [W-1:0]      data_out;
    logic [MODE_W-1:0] mode_cur;
    logic              frame_start;

    modport master (
        output mode_req,
        output mode_valid,
        input  mode_ready,
        input  data_out,
        input  mode_cur,
        input  frame_start
    );

    modport slave (
        input  mode_req,
        input  mode_valid,
        output mode_ready,
        output data_out,
        output mode_cur,
        output frame_start
    );

endinterface

// File: rtl/pattern_source_gen_prbs.sv
// Fibonacci LFSR producing W sequence bits per advance; the first bit of each
// word lands in word_o[W-1]. word_o is the word the current state will emit.
module prbs_lfsr_par
    import pattern_gen_pkg::*;
#(
    parameter int unsigned      ORDER = PRBS7_ORDER,
    parameter int unsigned      TAP   = PRBS7_TAP,
    parameter int unsigned      W     = 16,
    parameter logic [ORDER-1:0] SEED  = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         advance_i,
    output logic [W-1:0] word_o
);

    logic [ORDER-1:0] state_q;
    logic [ORDER-1:0] state_d;
    logic [ORDER-1:0] walk_s;
    logic             fb;

    always_comb begin
        walk_s = state_q;
        fb     = 1'b0;
        word_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            fb            = walk_s[ORDER-1] ^ walk_s[TAP-1];
            word_o[W-1-i] = fb;
            walk_s        = {walk_s[ORDER-2:0], fb};
        end
        state_d = walk_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            state_q <= SEED;
        end else if (advance_i) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pattern_source_gen.sv
// Multi-mode test-pattern source: one registered W-bit word per enabled cycle,
// frame-aligned mode switching via valid/ready, and single-word bit0 error injection.
module pattern_source_gen
    import pattern_gen_pkg::*;
#(
    parameter int unsigned            W         = 16,
    parameter int unsigned            FRAME_LEN = 64,
    parameter logic [W-1:0]           CONST_VAL = 16'hA5A5,
    parameter logic [PRBS_SEED_W-1:0] PRBS_SEED = '1
) (
    input  logic                 clk1280,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 inj_err,
    input  logic [W-1:0]         user_pat,
    pattern_source_gen_if.slave  bus
);

    localparam int unsigned   CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_LEN - 1);

    hs_state_e         hs_q, hs_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [MODE_W-1:0] mode_cur_q, mode_cur_d;
    logic [MODE_W-1:0] pend_mode_q, pend_mode_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [W-1:0]      data_q, data_d;
    logic              fs_q, fs_d;
    logic              err_pend_q, err_pend_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic [W-1:0]      walk_q, walk_d;

    logic              boundary;
    logic              restart;
    logic              adv7, adv15, adv31;
    logic [W-1:0]      prbs7_w, prbs15_w, prbs31_w;
    logic [W-1:0]      gen_word;

    assign boundary = enable && (word_cnt_q == LAST_WORD);
    assign adv7     = enable && (mode_q == MODE_PRBS7);
    assign adv15    = enable && (mode_q == MODE_PRBS15);
    assign adv31    = enable && (mode_q == MODE_PRBS31);

    prbs_lfsr_par #(
        .ORDER (PRBS7_ORDER),
        .TAP   (PRBS7_TAP),
        .W     (W),
        .SEED  (PRBS_SEED[PRBS7_ORDER-1:0])
    ) u_prbs7 (
        .clk_i     (clk1280),
        .rst_i     (rst),
        .load_i    (restart),
        .advance_i (adv7),
        .word_o    (prbs7_w)
    );

    prbs_lfsr_par #(
        .ORDER (PRBS15_ORDER),
        .TAP   (PRBS15_TAP),
        .W     (W),
        .SEED  (PRBS_SEED[PRBS15_ORDER-1:0])
    ) u_prbs15 (
        .clk_i     (clk1280),
        .rst_i     (rst),
        .load_i    (restart),
        .advance_i (adv15),
        .word_o    (prbs15_w)
    );

    prbs_lfsr_par #(
        .ORDER (PRBS31_ORDER),
        .TAP   (PRBS31_TAP),
        .W     (W),
        .SEED  (PRBS_SEED[PRBS31_ORDER-1:0])
    ) u_prbs31 (
        .clk_i     (clk1280),
        .rst_i     (rst),
        .load_i    (restart),
        .advance_i (adv31),
        .word_o    (prbs31_w)
    );

    // Switch is taken on the boundary word; ready returns once the first new-mode word is out
    always_comb begin
        hs_d    = hs_q;
        restart = 1'b0;
        case (hs_q)
            HS_IDLE: begin
                if (bus.mode_valid) hs_d = HS_PENDING;
            end
            HS_PENDING: begin
                if (boundary) begin
                    hs_d    = HS_COMMIT;
                    restart = 1'b1;
                end
            end
            HS_COMMIT: begin
                if (enable) hs_d = HS_IDLE;
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    always_comb begin
        case (mode_q)
            MODE_COUNT:     gen_word = cnt_q;
            MODE_PRBS7:     gen_word = prbs7_w;
            MODE_PRBS15:    gen_word = prbs15_w;
            MODE_PRBS31:    gen_word = prbs31_w;
            MODE_CONST:     gen_word = CONST_VAL;
            MODE_CONST_BAR: gen_word = ~CONST_VAL;
            MODE_WALK:      gen_word = walk_q;
            MODE_USER:      gen_word = user_pat;
            default:        gen_word = '0;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        fs_d        = 1'b0;
        mode_cur_d  = mode_cur_q;
        word_cnt_d  = word_cnt_q;
        cnt_d       = cnt_q;
        walk_d      = walk_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        err_pend_d  = inj_err | (err_pend_q & ~enable);

        if ((hs_q == HS_IDLE) && bus.mode_valid) pend_mode_d = bus.mode_req;

        if (enable) begin
            data_d     = gen_word ^ {{(W-1){1'b0}}, err_pend_q};
            fs_d       = (word_cnt_q == '0);
            mode_cur_d = mode_q;
            word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
            if (mode_q == MODE_COUNT) cnt_d = cnt_q + 1'b1;
            if (mode_q == MODE_WALK)  walk_d = {walk_q[W-2:0], walk_q[W-1]};
        end

        // Restart overrides the advance so the first new-mode word starts from the initial state
        if (restart) begin
            mode_d = pend_mode_q;
            cnt_d  = '0;
            walk_d = W'(1);
        end
    end

    always_ff @(posedge clk1280) begin
        if (rst) begin
            hs_q        <= HS_IDLE;
            mode_q      <= MODE_COUNT;
            mode_cur_q  <= MODE_COUNT;
            pend_mode_q <= MODE_COUNT;
            word_cnt_q  <= '0;
            data_q      <= '0;
            fs_q        <= 1'b0;
            err_pend_q  <= 1'b0;
            cnt_q       <= '0;
            walk_q      <= W'(1);
        end else begin
            hs_q        <= hs_d;
            mode_q      <= mode_d;
            mode_cur_q  <= mode_cur_d;
            pend_mode_q <= pend_mode_d;
            word_cnt_q  <= word_cnt_d;
            data_q      <= data_d;
            fs_q        <= fs_d;
            err_pend_q  <= err_pend_d;
            cnt_q       <= cnt_d;
            walk_q      <= walk_d;
        end
    end

    assign bus.mode_ready  = (hs_q == HS_IDLE);
    assign bus.data_out    = data_q;
    assign bus.mode_cur    = mode_cur_q;
    assign bus.frame_start = fs_q;

endmodule
